ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Parametrised instruction-fetch unit with a prefetch queue. Replaces the single-register PC/instruction latch.
- Keeps a fetch PC and issues request/acknowledge reads to instruction memory (RAM2).
- Buffers up to DEPTH fetched words together with their PCs.
- Presents the head entry to decode through a valid/stall handshake.
- Branch and interrupt redirects flush the queue; an in-flight read is retired and discarded.

Parameters:
ADDR_W, 16, fetch-address width
DATA_W, 16, instruction width
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 0, fetch PC after reset

Ports:
pci_clk  in  1  clock
pci_rst  in  1  reset, asynchronous, active-low
pci_stall  in  1  decode not consuming; head is popped when pco_valid=1 and pci_stall=0
pci_branch  in  1  redirect to pci_new_addr
pci_new_addr  in  ADDR_W  branch target
pci_interrupt  in  1  redirect to pci_epc; takes priority over pci_branch
pci_epc  in  ADDR_W  interrupt/exception target
pci_mem_ack  in  1  memory completed the current request; pci_mem_data valid this cycle
pci_mem_data  in  DATA_W  instruction word from RAM2
pco_mem_req  out  1  read request
pco_mem_addr  out  ADDR_W  read address
pco_ram2_oe  out  1  RAM2 output enable, active-low (equals ~pco_mem_req)
pco_valid  out  1  head entry valid
pco_instr  out  DATA_W  head instruction; 0 (NOP) when pco_valid=0
pco_instr_pc  out  ADDR_W  PC of head instruction
pco_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset values (async, while pci_rst=0):
  - fetch_pc=RESET_PC; queue empty; state FETCH.
  - pco_mem_req=0, pco_ram2_oe=1, pco_mem_addr=RESET_PC.
  - pco_valid=0, pco_instr=0, pco_instr_pc=0, pco_count=0.
- Request rules:
  - pco_mem_addr=fetch_pc at all times.
  - Request is raised only if count + outstanding < DEPTH.
  - Once raised, req and addr stay stable until ack.
  - Ack may come in the same cycle as req (zero-wait memory) or any later cycle.
  - On an accepted ack: fetch_pc increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
- FSM:
  - FETCH: req per the rule above. Ack without redirect pushes {fetch_pc, data}.
  - DRAIN: entered when a redirect occurs with req high and no ack in that cycle. req is held on the old address; the returning ack data is discarded; then FETCH at the new PC.
- Redirect (pci_interrupt | pci_branch), registered at the clock edge:
  - Queue cleared and pco_count=0 the next cycle.
  - fetch_pc = pci_epc if pci_interrupt, else pci_new_addr.
  - A pop in the same cycle is irrelevant.
  - An ack in the same cycle is discarded, and fetch_pc takes the target.
- Queue:
  - Push and pop in the same cycle leave count unchanged, including when full.
  - Pop when empty is ignored.
  - Push when full cannot occur, because slots are reserved at request time.
- Latency: an instruction acked in cycle N is visible at the head in N+1, with the queue empty and no redirect.
- Reset asserted mid-request drops req immediately; no DRAIN occurs after reset.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the queue is empty, an ack arrives and there is no redirect, pci_mem_data and fetch_pc drive pco_instr / pco_instr_pc combinationally with pco_valid=1 in the same cycle.
  - If pci_stall=0 the word is consumed and not pushed.
  - If pci_stall=1 the word is pushed as normal.
- Undefined: fetch-to-decode latency is always at least 1 cycle through the queue.

Decomposition:
- Package ifetch_pkg:
  - state enum {FETCH, DRAIN}
  - NOP constant (all zeros)
  - default ADDR_W/DATA_W
  - count-width function
- Sub-module ifq_fifo: DEPTH×(ADDR_W+DATA_W) circular buffer with rd/wr pointers, count, push/pop/clear. All control logic stays in ifetch_queue.

Test Plan:
- Reset release, zero-wait memory, pci_stall=0 → pco_instr_pc sequence 0,1,2,3… with one word per cycle after the 1-cycle latency.
- pci_stall=1 held, zero-wait memory → pco_count reaches 4, pco_mem_req=0 while full, pco_instr stays at the word from PC 0.
- Memory with 3-cycle ack, branch to 0x0040 asserted 1 cycle after req at 0x0005 → req/addr 0x0005 held until ack, data discarded, next request at 0x0040, first valid head pco_instr_pc=0x0040.
- pci_interrupt and pci_branch in the same cycle, epc=0x0100, new_addr=0x0200 → next fetch at 0x0100, queue flushed (pco_count=0, pco_valid=0).
- fetch_pc=0xFFFF, ack → next request address 0x0000, queued pc 0xFFFF.
- pci_rst low while a request is outstanding → pco_mem_req=0 and pco_ram2_oe=1 immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction-fetch queue.
//   ifq_state_e   : fetch controller state (FETCH / DRAIN)
//   DEF_ADDR_W    : default fetch-address width
//   DEF_DATA_W    : default instruction width
//   NOP_BIT       : replicated to build the all-zero NOP word
//   count_width() : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package ifetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // The NOP instruction is all zeros; replicate this bit to DATA_W.
  localparam logic NOP_BIT = 1'b0;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
// Circular buffer of DEPTH entries, WIDTH bits each, for the fetch queue.
// The head entry is readable combinationally so decode sees it in the cycle
// after it was written.
// Ports:
//   pci_clk  : clock
//   pci_rst  : asynchronous active-low reset (pointers and count)
//   push     : write wr_data at the tail
//   pop      : discard the head entry (ignored when empty)
//   clear    : empty the buffer; overrides push and pop
//   wr_data  : tail write data
//   rd_data  : head entry contents (undefined when count == 0)
//   count    : occupied entries, 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// ---------------------------------------------------------------------------
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          pci_clk,
  input  logic                          pci_rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          clear,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; the tail slot is then the one being vacated.
  assign do_push = push && !clear && (!full || do_pop);

  // Storage has no reset: contents are only meaningful while counted.
  always_ff @(posedge pci_clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// Instruction-fetch unit with a DEPTH-entry prefetch queue. Keeps a fetch PC,
// reads instruction memory (RAM2) with a req/ack handshake, queues the
// fetched words with their PCs and presents the head to decode.
// Branch/interrupt redirects flush the queue; a read that is still in flight
// at the redirect is completed and its data thrown away (DRAIN state).
//
// Optional build macro:
//   IFQ_BYPASS_EN : when the queue is empty, a fresh ack is forwarded to
//                   decode in the same cycle (and not queued if consumed).
//
// Ports:
//   pci_clk        : clock
//   pci_rst        : asynchronous active-low reset
//   pci_stall      : decode not consuming; head pops when valid && !stall
//   pci_branch     : redirect to pci_new_addr
//   pci_new_addr   : branch target
//   pci_interrupt  : redirect to pci_epc (wins over pci_branch)
//   pci_epc        : interrupt/exception target
//   pci_mem_ack    : memory completed the current request this cycle
//   pci_mem_data   : instruction word, valid with pci_mem_ack
//   pco_mem_req    : read request
//   pco_mem_addr   : read address (always the fetch PC)
//   pco_ram2_oe    : RAM2 output enable, active-low
//   pco_valid      : head entry valid
//   pco_instr      : head instruction, NOP when not valid
//   pco_instr_pc   : PC of the head instruction, 0 when not valid
//   pco_count      : occupied queue entries
// ---------------------------------------------------------------------------
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          pci_clk,
  input  logic                          pci_rst,
  input  logic                          pci_stall,
  input  logic                          pci_branch,
  input  logic [ADDR_W-1:0]             pci_new_addr,
  input  logic                          pci_interrupt,
  input  logic [ADDR_W-1:0]             pci_epc,
  input  logic                          pci_mem_ack,
  input  logic [DATA_W-1:0]             pci_mem_data,
  output logic                          pco_mem_req,
  output logic [ADDR_W-1:0]             pco_mem_addr,
  output logic                          pco_ram2_oe,
  output logic                          pco_valid,
  output logic [DATA_W-1:0]             pco_instr,
  output logic [ADDR_W-1:0]             pco_instr_pc,
  output logic [count_width(DEPTH)-1:0] pco_count
);

  localparam int CNT_W   = count_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  ifq_state_e        state_reg;
  ifq_state_e        state_next;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] target_reg;
  logic [ADDR_W-1:0] target_next;
  // Holds requests off for the first cycle after reset release so that the
  // request line is a pure function of registered state.
  logic              run_reg;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              req;
  logic              accept;
  logic              bypass_hit;
  logic              push;
  logic              pop;
  logic              clear;

  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               head_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_instr;

  assign redirect    = pci_interrupt | pci_branch;
  assign redirect_pc = pci_interrupt ? pci_epc : pci_new_addr;

  // At most one read is ever outstanding and it is the one currently being
  // requested, so "count + outstanding < DEPTH" reduces to count < DEPTH.
  // While waiting for an ack, count can only fall, so req stays high.
  // In DRAIN the queue is already empty and the old request is held.
  assign req    = run_reg && ((state_reg == DRAIN) || (fifo_count < CNT_W'(DEPTH)));
  assign accept = req && pci_mem_ack;

  assign head_valid = (fifo_count != '0);
  assign head_pc    = head_entry[ENTRY_W-1:DATA_W];
  assign head_instr = head_entry[DATA_W-1:0];

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = (state_reg == FETCH) && accept && !redirect && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // Redirect makes any same-cycle pop irrelevant: the clear wins anyway.
  assign pop = head_valid && !pci_stall && !redirect;

  // -------------------------------------------------------------------------
  // Controller: next-state, fetch PC and queue control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    target_next   = target_reg;
    push          = 1'b0;
    clear         = 1'b0;

    case (state_reg)
      FETCH: begin
        if (redirect) begin
          clear = 1'b1;
          if (req && !pci_mem_ack) begin
            // The read cannot be withdrawn: keep it on the old address and
            // remember where to go once it completes.
            state_next  = DRAIN;
            target_next = redirect_pc;
          end else begin
            // No read pending, or it completed now and is discarded.
            fetch_pc_next = redirect_pc;
          end
        end else if (accept) begin
          fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
          // A bypassed word that decode takes right away is not queued.
          push = !(bypass_hit && !pci_stall);
        end
      end

      DRAIN: begin
        if (redirect) begin
          clear       = 1'b1;
          target_next = redirect_pc;
        end
        if (accept) begin
          state_next    = FETCH;
          fetch_pc_next = redirect ? redirect_pc : target_reg;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      target_reg   <= RESET_PC;
      run_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      target_reg   <= target_next;
      run_reg      <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch queue: each entry is {pc, instruction}
  // -------------------------------------------------------------------------
  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pci_clk (pci_clk),
    .pci_rst (pci_rst),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data ({fetch_pc_reg, pci_mem_data}),
    .rd_data (head_entry),
    .count   (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pco_mem_req  = req;
  assign pco_mem_addr = fetch_pc_reg;
  assign pco_ram2_oe  = ~req;
  assign pco_count    = fifo_count;

  always_comb begin
    pco_valid    = 1'b0;
    pco_instr    = {DATA_W{NOP_BIT}};
    pco_instr_pc = '0;
    if (bypass_hit) begin
      pco_valid    = 1'b1;
      pco_instr    = pci_mem_data;
      pco_instr_pc = fetch_pc_reg;
    end else if (head_valid) begin
      pco_valid    = 1'b1;
      pco_instr    = head_instr;
      pco_instr_pc = head_pc;
    end
  end

endmodule
